fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC loaded on reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of granted but unanswered imem requests (legal values 1..2).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 stall  in  1  downstream fetch/decode register is holding; head entry is not consumed.
REQ-006 redirect  in  1  branch/jump taken; fetch restarts at redirect_pc.
REQ-007 redirect_pc  in  32  new fetch address; bits [1:0] are ignored (forced 0).
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word-aligned request address.
REQ-010 imem_gnt  in  1  request accepted this cycle when imem_req=1.
REQ-011 imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after grant.
REQ-012 imem_rdata  in  32  response instruction word.
REQ-013 InstrF  out  32  head instruction toward the fetch/decode register.
REQ-014 PCF  out  32  PC of InstrF.
REQ-015 validF  out  1  InstrF/PCF hold a real fetched instruction.

Function
REQ-016 The block SHALL hold fetch_pc (next address to request), a 2-entry in-order buffer of {pc, instr}, an outstanding counter (0..2) and a drop counter (0..2).
REQ-017 imem_req SHALL be 1 when outstanding < MAX_OUTSTANDING and (buffer occupancy + outstanding) < 2 and redirect=0; imem_addr SHALL equal fetch_pc.
REQ-018 Once imem_req=1 without imem_gnt, imem_req and imem_addr SHALL stay stable until grant, unless redirect=1 arrives, which SHALL withdraw the request that cycle.
REQ-019 On imem_req & imem_gnt, fetch_pc SHALL increment by 4 (modulo 2^32, 32'hFFFFFFFC wraps to 0) and outstanding SHALL increment; the issued pc SHALL be recorded in an in-order pc queue.
REQ-020 On imem_rvalid with drop counter = 0, {queued pc, imem_rdata} SHALL be written to the buffer tail and outstanding SHALL decrement; zero-latency pass-through from imem_rdata to InstrF is not permitted (latency imem_rvalid -> validF = 1 cycle).
REQ-021 On imem_rvalid with drop counter > 0, the response SHALL be discarded and both drop and outstanding SHALL decrement.
REQ-022 When the buffer is empty, validF SHALL be 0, InstrF SHALL be 32'h00000013 (NOP) and PCF SHALL be 0.
REQ-023 The head entry SHALL be popped on posedge when validF=1 and stall=0 and redirect=0; simultaneous pop and push SHALL keep occupancy unchanged.
REQ-024 On redirect=1: fetch_pc <= redirect_pc with [1:0] cleared; buffer emptied; drop <= outstanding, counting a response accepted that same cycle as already resolved and counting a grant accepted that same cycle as an additional drop.
REQ-025 redirect SHALL take priority over stall; the next cycle validF=0.
REQ-026 A buffer write while full SHALL be impossible by construction of REQ-017; no overflow path SHALL exist.
REQ-027 imem_rvalid when outstanding = 0 SHALL be ignored.

Reset
REQ-028 On rst_n=0, asynchronously: fetch_pc=RESET_PC, buffer empty, outstanding=0, drop=0, imem_req=0, validF=0, InstrF=32'h00000013, PCF=0.
REQ-029 Responses to requests granted before a mid-operation reset SHALL be ignored after reset release only through REQ-027 (memory is reset by the same rst_n).
REQ-030 The first request SHALL be raised in the first cycle after rst_n deasserts.

Configuration
REQ-031 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs bubble_cnt (32) incrementing each cycle validF=0 and stall=0, and redirect_cnt (32) incrementing each cycle redirect=1, both reset to 0 and wrapping at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN, those ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-033 Reset release, RESET_PC=0, gnt=1 always, rvalid 1 cycle after grant, rdata=addr+32'h100 -> PCF sequence 0,4,8 on consecutive cycles, InstrF 32'h100,32'h104,32'h108.
REQ-034 stall=1 for 5 cycles while streaming -> PCF/InstrF frozen, imem_req drops after occupancy+outstanding=2, no entry lost or duplicated after release.
REQ-035 redirect=1, redirect_pc=32'h00000203 with 2 outstanding -> next imem_addr=32'h00000200, two following responses discarded, first validF=1 shows PCF=32'h200.
REQ-036 imem_gnt=0 for 4 cycles -> imem_req=1 and imem_addr constant throughout; redirect in cycle 3 withdraws req and retargets.
REQ-037 fetch_pc=32'hFFFFFFFC granted -> next imem_addr=32'h00000000.
REQ-038 rst_n pulsed low mid-stream for half a cycle -> outputs immediately at reset values; stray rvalid afterwards produces no validF.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order imem requester with a 2-entry {pc, instr} buffer.
// Optional perf counters (bubble_cnt, redirect_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        validF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [1:0]  MAX_OUT = 2'(MAX_OUTSTANDING);

    logic [31:0] fetch_pc;
    logic [31:0] pcq   [2];
    logic [31:0] bpc   [2];
    logic [31:0] binstr[2];
    logic [1:0]  occ;
    logic [1:0]  outstanding;
    logic [1:0]  drop;

    logic [2:0]  inflight;
    logic        grant;
    logic        resp;
    logic        push;
    logic        pop;
    logic        pq_widx;
    logic        bw_idx;
    logic [1:0]  out_next;

    always_comb begin
        inflight  = {1'b0, occ} + {1'b0, outstanding};
        // Gated by rst_n so the request is low during reset and rises as soon as it releases.
        imem_req  = rst_n && (outstanding < MAX_OUT) && (inflight < 3'd2) && !redirect;
        imem_addr = fetch_pc;
        grant     = imem_req && imem_gnt;
        resp      = imem_rvalid && (outstanding != 2'd0);
        push      = resp && (drop == 2'd0) && !redirect;
        pop       = (occ != 2'd0) && !stall && !redirect;
        pq_widx   = (outstanding == 2'd1) && !resp;
        bw_idx    = (occ == 2'd1) && !pop;
        out_next  = 2'(outstanding + {1'b0, grant} - {1'b0, resp});
        validF    = (occ != 2'd0);
        InstrF    = validF ? binstr[0] : NOP;
        PCF       = validF ? bpc[0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            occ         <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                pcq[i]    <= '0;
                bpc[i]    <= '0;
                binstr[i] <= '0;
            end
        end else begin
            outstanding <= out_next;
            if (resp)
                pcq[0] <= pcq[1];
            if (grant)
                pcq[pq_widx] <= fetch_pc;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                occ      <= '0;
                // Every request still in flight after this edge belongs to the abandoned stream.
                drop     <= out_next;
            end else begin
                if (grant)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp && (drop != 2'd0))
                    drop <= drop - 2'd1;
                occ <= 2'(occ + {1'b0, push} - {1'b0, pop});
                if (pop) begin
                    bpc[0]    <= bpc[1];
                    binstr[0] <= binstr[1];
                end
                if (push) begin
                    bpc[bw_idx]    <= pcq[0];
                    binstr[bw_idx] <= imem_rdata;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            if (!validF && !stall)
                bubble_cnt <= bubble_cnt + 32'd1;
            if (redirect)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized imem model plus a stream-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic        validF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] redirect_cnt;
`endif

    fetch_unit #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrF(InstrF), .PCF(PCF), .validF(validF)
`ifdef FETCH_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    int unsigned beats = 0;
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    bit          stray_rv = 1'b0;

    // Reference: expected delivered pc stream and expected next request address.
    logic [31:0] exp_pc = RPC;
    logic [31:0] mdl_fetch = RPC;
    logic [31:0] mq_addr[$];
    int unsigned mq_ready[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];
    int unsigned dlv_cyc[$];

    bit          prev_pend, prev_hold, prev_redir;
    logic [31:0] prev_addr, prev_pcf, prev_instr;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pcf, s_instr;

    task automatic model_reset();
        exp_pc = RPC;
        mdl_fetch = RPC;
        mq_addr.delete();
        mq_ready.delete();
        prev_pend = 1'b0;
        prev_hold = 1'b0;
        prev_redir = 1'b0;
    endtask

    // One clock: drive memory at posedge+1, sample/compare at the negedge, advance.
    task automatic cycle();
        bit rv;
        bit grant;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        rv = stray_rv || (mq_addr.size() != 0 && mq_ready[0] <= cyc);
        imem_rvalid = rv;
        if (stray_rv) imem_rdata = 32'hDEAD_BEEF;
        else if (rv) imem_rdata = mq_addr[0] + 32'h100;
        else imem_rdata = $urandom();
        #4;
        s_req = imem_req; s_addr = imem_addr; s_valid = validF; s_pcf = PCF; s_instr = InstrF;
        if (redirect) begin
            checks++;
            if (s_req !== 1'b0) begin failures++; $display("FAIL redirect_withdraw cyc=%0d req=%b want 0", cyc, s_req); end
        end
        if (prev_pend && !redirect) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== prev_addr) begin
                failures++; $display("FAIL req_hold cyc=%0d req=%b addr=%h want 1/%h", cyc, s_req, s_addr, prev_addr);
            end
        end
        if (s_req === 1'b1) begin
            checks++;
            if (s_addr !== mdl_fetch) begin failures++; $display("FAIL req_addr cyc=%0d addr=%h want %h", cyc, s_addr, mdl_fetch); end
        end
        if (s_valid === 1'b0) begin
            checks++;
            if (s_pcf !== 32'h0 || s_instr !== NOP) begin
                failures++; $display("FAIL empty_out cyc=%0d pc=%h instr=%h want 0/%h", cyc, s_pcf, s_instr, NOP);
            end
        end
        if (prev_redir) begin
            checks++;
            if (s_valid !== 1'b0) begin failures++; $display("FAIL valid_after_redirect cyc=%0d valid=%b want 0", cyc, s_valid); end
        end
        if (prev_hold) begin
            checks++;
            if (s_valid !== 1'b1 || s_pcf !== prev_pcf || s_instr !== prev_instr) begin
                failures++; $display("FAIL stall_freeze cyc=%0d v=%b pc=%h instr=%h want 1/%h/%h", cyc, s_valid, s_pcf, s_instr, prev_pcf, prev_instr);
            end
        end
        if (s_valid === 1'b1 && !stall && !redirect) begin
            checks++;
            if (s_pcf !== exp_pc || s_instr !== exp_pc + 32'h100) begin
                failures++; $display("FAIL beat cyc=%0d pc=%h instr=%h want %h/%h", cyc, s_pcf, s_instr, exp_pc, exp_pc + 32'h100);
            end
            dlv_pc.push_back(s_pcf); dlv_instr.push_back(s_instr); dlv_cyc.push_back(cyc);
            exp_pc += 32'd4;
            beats++;
        end
        grant = (s_req === 1'b1) && imem_gnt;
        if (rv && !stray_rv) begin
            void'(mq_addr.pop_front());
            void'(mq_ready.pop_front());
        end
        if (grant) begin
            mq_addr.push_back(s_addr);
            mq_ready.push_back(cyc + $urandom_range(lat_max, lat_min));
        end
        checks++;
        if (mq_addr.size() > MAXO) begin failures++; $display("FAIL outstanding_limit cyc=%0d n=%0d want <=%0d", cyc, mq_addr.size(), MAXO); end
        if (redirect) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
            mdl_fetch = exp_pc;
        end else if (grant) begin
            mdl_fetch += 32'd4;
        end
        prev_pend = (s_req === 1'b1) && !imem_gnt && !redirect;
        prev_addr = s_addr;
        prev_hold = (s_valid === 1'b1) && stall && !redirect;
        prev_redir = redirect;
        prev_pcf = s_pcf;
        prev_instr = s_instr;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1; #4;
        checks++;
        if (imem_req !== 1'b0 || validF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0) begin
            failures++; $display("FAIL reset_values req=%b v=%b instr=%h pc=%h want 0/0/%h/0", imem_req, validF, InstrF, PCF, NOP);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            failures++; $display("FAIL first_req req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_stream();
        int unsigned k0 = cyc;
        int unsigned n0 = dlv_pc.size();
        gnt_pct = 100; lat_min = 1; lat_max = 1; stall = 1'b0;
        for (int i = 0; i < 30 && dlv_pc.size() < n0 + 3; i++) cycle();
        checks++;
        if (dlv_pc.size() < n0 + 3) begin
            failures++; $display("FAIL stream_timeout beats=%0d want 3", dlv_pc.size() - n0);
        end else begin
            checks++;
            if (dlv_pc[n0] !== 32'h0 || dlv_pc[n0+1] !== 32'h4 || dlv_pc[n0+2] !== 32'h8) begin
                failures++; $display("FAIL stream_pcs got %h,%h,%h want 0,4,8", dlv_pc[n0], dlv_pc[n0+1], dlv_pc[n0+2]);
            end
            checks++;
            if (dlv_instr[n0] !== 32'h100 || dlv_instr[n0+1] !== 32'h104 || dlv_instr[n0+2] !== 32'h108) begin
                failures++; $display("FAIL stream_instrs got %h,%h,%h want 100,104,108", dlv_instr[n0], dlv_instr[n0+1], dlv_instr[n0+2]);
            end
            checks++;
            if (dlv_cyc[n0] != k0 + 2) begin
                failures++; $display("FAIL first_latency cyc=%0d want %0d", dlv_cyc[n0], k0 + 2);
            end
        end
        repeat (10) cycle();
    endtask

    task automatic test_stall();
        int unsigned b0;
        gnt_pct = 100; lat_min = 1; lat_max = 2; stall = 1'b0;
        for (int i = 0; i < 20 && s_valid !== 1'b1; i++) cycle();
        stall = 1'b1;
        repeat (5) cycle();
        checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            failures++; $display("FAIL stall_backpressure req=%b valid=%b want 0/1", s_req, s_valid);
        end
        stall = 1'b0;
        b0 = beats;
        repeat (20) cycle();
        checks++;
        if (beats < b0 + 4) begin failures++; $display("FAIL stall_resume beats=%0d want >=4", beats - b0); end
    endtask

    task automatic test_redirect();
        int unsigned n0;
        gnt_pct = 0; lat_min = 1; lat_max = 1; stall = 1'b0;
        repeat (8) cycle();
        gnt_pct = 100; lat_min = 4; lat_max = 4;
        cycle(); cycle();
        checks++;
        if (mq_addr.size() != 2) begin failures++; $display("FAIL redirect_setup outstanding=%0d want 2", mq_addr.size()); end
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        cycle();
        redirect = 1'b0;
        n0 = dlv_pc.size();
        cycle();
        checks++;
        if (s_addr !== 32'h0000_0200) begin failures++; $display("FAIL redirect_target addr=%h want 00000200", s_addr); end
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 30 && dlv_pc.size() == n0; i++) cycle();
        checks++;
        if (dlv_pc.size() == n0) begin
            failures++; $display("FAIL redirect_timeout no beat after redirect");
        end else if (dlv_pc[n0] !== 32'h0000_0200) begin
            failures++; $display("FAIL redirect_first pc=%h want 00000200", dlv_pc[n0]);
        end
    endtask

    task automatic test_gnt_hold();
        logic [31:0] held;
        int unsigned n0;
        gnt_pct = 0; lat_min = 1; lat_max = 1; stall = 1'b0;
        repeat (8) cycle();
        cycle();
        held = s_addr;
        checks++;
        if (s_req !== 1'b1) begin failures++; $display("FAIL gnt_hold_c1 req=%b want 1", s_req); end
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== held) begin
            failures++; $display("FAIL gnt_hold_c2 req=%b addr=%h want 1/%h", s_req, s_addr, held);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0340;
        cycle();
        redirect = 1'b0;
        checks++;
        if (s_req !== 1'b0) begin failures++; $display("FAIL gnt_hold_withdraw req=%b want 0", s_req); end
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0340) begin
            failures++; $display("FAIL gnt_hold_retarget req=%b addr=%h want 1/00000340", s_req, s_addr);
        end
        gnt_pct = 100;
        n0 = dlv_pc.size();
        for (int i = 0; i < 20 && dlv_pc.size() == n0; i++) cycle();
        checks++;
        if (dlv_pc.size() == n0 || dlv_pc[n0] !== 32'h0000_0340) begin
            failures++; $display("FAIL gnt_hold_first got %0d beats, want first pc 00000340", dlv_pc.size() - n0);
        end
    endtask

    task automatic test_wrap();
        int unsigned n0;
        bit found = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 2; stall = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF6;
        cycle();
        redirect = 1'b0;
        n0 = dlv_pc.size();
        for (int i = 0; i < 40 && dlv_pc.size() < n0 + 4; i++) cycle();
        for (int i = n0; i + 1 < dlv_pc.size(); i++)
            if (dlv_pc[i] == 32'hFFFF_FFFC && dlv_pc[i+1] == 32'h0) found = 1'b1;
        checks++;
        if (!found) begin failures++; $display("FAIL wrap beats=%0d want FFFFFFFC then 00000000", dlv_pc.size() - n0); end
    endtask

    task automatic test_random();
        int unsigned b0 = beats;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            gnt_pct = 70;
            stall = ($urandom_range(99) < 30);
            redirect = ($urandom_range(99) < 5);
            redirect_pc = $urandom();
            cycle();
        end
        redirect = 1'b0; stall = 1'b0;
        repeat (10) cycle();
        checks++;
        if (beats < b0 + 50) begin failures++; $display("FAIL random_progress beats=%0d want >=50", beats - b0); end
    endtask

    task automatic test_reset_mid();
        int unsigned n0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; stall = 1'b0;
        for (int i = 0; i < 20 && s_valid !== 1'b1; i++) cycle();
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || validF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0) begin
            failures++; $display("FAIL midreset_values req=%b v=%b instr=%h pc=%h want 0/0/%h/0", imem_req, validF, InstrF, PCF, NOP);
        end
        #4;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        cyc++;
        gnt_pct = 0;
        stray_rv = 1'b1;
        cycle();
        stray_rv = 1'b0;
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin failures++; $display("FAIL stray_rvalid valid=%b want 0", s_valid); end
        gnt_pct = 100;
        n0 = dlv_pc.size();
        for (int i = 0; i < 20 && dlv_pc.size() == n0; i++) cycle();
        checks++;
        if (dlv_pc.size() == n0 || dlv_pc[n0] !== RPC) begin
            failures++; $display("FAIL midreset_restart got %0d beats, want first pc %h", dlv_pc.size() - n0, RPC);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_gnt_hold();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
